pipe_stage_register: RTL and testbench
======================================

Name: pipe_stage_register

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries one control field and one data field between any two pipeline stages. Uses a valid/ready handshake with a one-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Adds synchronous flush for branch/jump squash, bubble insertion (NOP control when invalid), an occupancy output and a saturating stall counter for performance monitoring.

Parameters:
- CTRL_WIDTH, 16: width of control field (RegWrite, MemRead, ALUOp, ...); cleared on bubble/flush.
- DATA_WIDTH, 128: width of data field (operands, immediate, instruction, PC+4); not cleared on flush.
- NOP_CTRL, {CTRL_WIDTH{1'b0}}: control value presented whenever out_valid=0.
- CNT_WIDTH, 16: width of stall_count.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream stage presents an instruction.
- in_ready, output, 1: stage can accept; transfer when in_valid & in_ready.
- in_ctrl, input, CTRL_WIDTH: upstream control field.
- in_data, input, DATA_WIDTH: upstream data field.
- flush, input, 1: squash all held and incoming entries.
- out_valid, output, 1: downstream holds a valid instruction.
- out_ready, input, 1: downstream accepts; transfer when out_valid & out_ready.
- out_ctrl, output, CTRL_WIDTH: main_ctrl if out_valid, else NOP_CTRL.
- out_data, output, DATA_WIDTH: main_data; unchanged/don't-care when invalid.
- occupancy, output, 2: number of held entries, 0..2.
- stall_count, output, CNT_WIDTH: cycles with out_valid & !out_ready, saturating.

Behaviour:
- Reset (reset=0, async):
  - main_valid=0, skid_valid=0.
  - Control regs = NOP_CTRL; data regs = 0; stall_count=0.
  - Outputs during reset: out_valid=0, out_ctrl=NOP_CTRL, in_ready=1, occupancy=0.
  - Reset mid-operation discards all entries immediately.
- Storage: main register (drives outputs) and skid register.
- in_ready = !skid_valid. Combinational from state only; no path from out_ready (registered ready).
- Latency and throughput: empty stage gives 1 cycle from accept to out_valid. Sustains 1 transfer/cycle while out_ready=1.
- Per rising edge, when flush=0. Let acc = in_valid & in_ready and drn = out_valid & out_ready.
  - main empty, acc: main <= input.
  - main full, drn, skid full: main <= skid; skid_valid <= 0. acc is impossible in this case.
  - main full, drn, skid empty, acc: main <= input.
  - main full, drn, skid empty, !acc: main_valid <= 0.
  - main full, !drn, acc: skid <= input; skid_valid <= 1.
  - Otherwise hold.
- Ordering is strictly FIFO: a skid entry always precedes any newer input.
- Flush (synchronous, highest priority):
  - Next state main_valid=0, skid_valid=0, control regs <= NOP_CTRL.
  - An input handshaking in the flush cycle is dropped. A downstream drain in the flush cycle still completes; the downstream sees it.
  - in_ready=1 the cycle after flush.
- Simultaneous flush and reset: reset dominates.
- occupancy = main_valid + skid_valid.
- stall_count:
  - Increments on each edge where out_valid & !out_ready.
  - Holds at 2^CNT_WIDTH-1.
  - Cleared only by reset; unaffected by flush.
- Invariant: skid_valid=1 implies main_valid=1.

Test Plan:
- Reset release, in_valid=1, in_ctrl=16'h00A5, in_data=D0, out_ready=1 -> out_valid=1 one cycle later with out_ctrl=16'h00A5, out_data=D0; occupancy=1.
- Streaming 8 entries D0..D7 with out_ready=1 throughout -> 8 consecutive out_valid cycles in order, in_ready stays 1, stall_count=0.
- Streaming with out_ready=0 for 3 cycles -> occupancy rises to 2, in_ready=0 from the 2nd stall cycle, stall_count=3. Release -> D0, D1, D2 emerge in order, no loss or duplicates.
- Occupancy 2, then flush=1 with in_valid=1 (D9), out_ready=0 -> next cycle out_valid=0, out_ctrl=NOP_CTRL, occupancy=0, in_ready=1; D9 never appears.
- reset asserted asynchronously mid-stream between clock edges -> out_valid drops to 0 and out_ctrl=NOP_CTRL immediately, without waiting for a clock edge.
- CNT_WIDTH=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_count saturates at 15 and holds.

Source files
------------

// File: rtl/pipe_stage_register.sv
// Elastic pipeline stage register: one control field plus one data field,
// valid/ready handshake with a one-entry skid buffer, synchronous flush,
// bubble insertion on the control field, occupancy reporting and a
// saturating stall counter for performance monitoring.
module pipe_stage_register #(
  parameter int                    CTRL_WIDTH = 16,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [CTRL_WIDTH-1:0] NOP_CTRL   = {CTRL_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic                  mainValidQ, mainValidD;
  logic                  skidValidQ, skidValidD;
  logic [CTRL_WIDTH-1:0] mainCtrlQ,  mainCtrlD;
  logic [CTRL_WIDTH-1:0] skidCtrlQ,  skidCtrlD;
  logic [DATA_WIDTH-1:0] mainDataQ,  mainDataD;
  logic [DATA_WIDTH-1:0] skidDataQ,  skidDataD;
  logic [CNT_WIDTH-1:0]  stallCountQ, stallCountD;

  logic accept;
  logic drain;

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready    = !skidValidQ;
  assign out_valid   = mainValidQ;
  assign out_ctrl    = mainValidQ ? mainCtrlQ : NOP_CTRL;
  assign out_data    = mainDataQ;
  assign occupancy   = {1'b0, mainValidQ} + {1'b0, skidValidQ};
  assign stall_count = stallCountQ;

  assign accept = in_valid && !skidValidQ;
  assign drain  = mainValidQ && out_ready;

  // Next-state selection for main/skid entries; flush wins over every handshake.
  always_comb begin
    mainValidD = mainValidQ;
    skidValidD = skidValidQ;
    mainCtrlD  = mainCtrlQ;
    skidCtrlD  = skidCtrlQ;
    mainDataD  = mainDataQ;
    skidDataD  = skidDataQ;
    if (flush) begin
      mainValidD = 1'b0;
      skidValidD = 1'b0;
      mainCtrlD  = NOP_CTRL;
      skidCtrlD  = NOP_CTRL;
    end else if (!mainValidQ) begin
      if (accept) begin
        mainValidD = 1'b1;
        mainCtrlD  = in_ctrl;
        mainDataD  = in_data;
      end
    end else if (drain) begin
      if (skidValidQ) begin
        mainCtrlD  = skidCtrlQ;
        mainDataD  = skidDataQ;
        skidValidD = 1'b0;
      end else if (accept) begin
        mainCtrlD  = in_ctrl;
        mainDataD  = in_data;
      end else begin
        mainValidD = 1'b0;
      end
    end else if (accept) begin
      skidValidD = 1'b1;
      skidCtrlD  = in_ctrl;
      skidDataD  = in_data;
    end
  end

  // Stall counter counts cycles the downstream refuses a valid entry and sticks at max.
  always_comb begin
    stallCountD = stallCountQ;
    if (mainValidQ && !out_ready && (stallCountQ != CntMax)) begin
      stallCountD = stallCountQ + 1'b1;
    end
  end

  // State registers; reset empties the stage immediately and clears the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainValidQ  <= 1'b0;
      skidValidQ  <= 1'b0;
      mainCtrlQ   <= NOP_CTRL;
      skidCtrlQ   <= NOP_CTRL;
      mainDataQ   <= '0;
      skidDataQ   <= '0;
      stallCountQ <= '0;
    end else begin
      mainValidQ  <= mainValidD;
      skidValidQ  <= skidValidD;
      mainCtrlQ   <= mainCtrlD;
      skidCtrlQ   <= skidCtrlD;
      mainDataQ   <= mainDataD;
      skidDataQ   <= skidDataD;
      stallCountQ <= stallCountD;
    end
  end

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed testbench for pipe_stage_register (CNT_WIDTH reduced to 4 so
// saturation is reachable quickly).
module tb_pipe_stage_register;

  localparam int CW = 16;
  localparam int DW = 128;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_count;

  int vecCount  = 0;
  int missCount = 0;

  pipe_stage_register #(
    .CTRL_WIDTH(CW),
    .DATA_WIDTH(DW),
    .NOP_CTRL  ({CW{1'b0}}),
    .CNT_WIDTH (NW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 + i;
    return {w, ~w, w, 32'h1234_0000 + i};
  endfunction

  // Advance past the next rising edge and settle a little after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs idle and hold reset for two edges, release away from the edge.
  task automatic applyReset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h00FF;
    in_data   = dval(99);
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecCount++;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    vecCount++;
    if (out_ctrl !== 16'h0000) begin missCount++; $display("[TB] FAIL reset_out_ctrl: got %0h expected 0", out_ctrl); end
    vecCount++;
    if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    vecCount++;
    if (occupancy !== 2'd0) begin missCount++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    vecCount++;
    if (stall_count !== 4'd0) begin missCount++; $display("[TB] FAIL reset_stall_count: got %0d expected 0", stall_count); end
    in_valid = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_single();
    applyReset();
    in_valid  = 1'b1;
    in_ctrl   = 16'h00A5;
    in_data   = dval(0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vecCount++;
    if (out_valid !== 1'b1) begin missCount++; $display("[TB] FAIL single_out_valid: got %0b expected 1", out_valid); end
    vecCount++;
    if (out_ctrl !== 16'h00A5) begin missCount++; $display("[TB] FAIL single_out_ctrl: got %0h expected a5", out_ctrl); end
    vecCount++;
    if (out_data !== dval(0)) begin missCount++; $display("[TB] FAIL single_out_data: got %0h expected %0h", out_data, dval(0)); end
    vecCount++;
    if (occupancy !== 2'd1) begin missCount++; $display("[TB] FAIL single_occupancy: got %0d expected 1", occupancy); end
    step();
    vecCount++;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL single_drained_valid: got %0b expected 0", out_valid); end
    vecCount++;
    if (out_ctrl !== 16'h0000) begin missCount++; $display("[TB] FAIL single_bubble_ctrl: got %0h expected 0", out_ctrl); end
  endtask

  task automatic test_streaming();
    applyReset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 16'(i + 1);
      in_data  = dval(i);
      step();
      vecCount++;
      if (out_valid !== 1'b1 || out_data !== dval(i) || out_ctrl !== 16'(i + 1)) begin
        missCount++;
        $display("[TB] FAIL stream_entry%0d: got v=%0b c=%0h d=%0h expected v=1 c=%0h d=%0h",
                 i, out_valid, out_ctrl, out_data, 16'(i + 1), dval(i));
      end
      vecCount++;
      if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL stream_in_ready%0d: got %0b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    vecCount++;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL stream_end_valid: got %0b expected 0", out_valid); end
    vecCount++;
    if (stall_count !== 4'd0) begin missCount++; $display("[TB] FAIL stream_stall_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_stall();
    applyReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0010;
    in_data   = dval(10);
    step();
    vecCount++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      missCount++; $display("[TB] FAIL stall_cycle1: got occ=%0d rdy=%0b expected occ=1 rdy=1", occupancy, in_ready);
    end
    in_ctrl = 16'h0011;
    in_data = dval(11);
    step();
    vecCount++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      missCount++; $display("[TB] FAIL stall_cycle2: got occ=%0d rdy=%0b expected occ=2 rdy=0", occupancy, in_ready);
    end
    in_ctrl = 16'h0012;
    in_data = dval(12);
    step();
    step();
    vecCount++;
    if (stall_count !== 4'd3) begin missCount++; $display("[TB] FAIL stall_count3: got %0d expected 3", stall_count); end
    vecCount++;
    if (out_data !== dval(10) || out_ctrl !== 16'h0010) begin
      missCount++; $display("[TB] FAIL stall_head_D0: got c=%0h d=%0h expected c=10 d=%0h", out_ctrl, out_data, dval(10));
    end
    out_ready = 1'b1;
    step();
    vecCount++;
    if (out_data !== dval(11) || out_ctrl !== 16'h0011 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL stall_release_D1: got c=%0h d=%0h occ=%0d rdy=%0b expected c=11 d=%0h occ=1 rdy=1",
               out_ctrl, out_data, occupancy, in_ready, dval(11));
    end
    step();
    in_valid = 1'b0;
    vecCount++;
    if (out_valid !== 1'b1 || out_data !== dval(12) || out_ctrl !== 16'h0012) begin
      missCount++; $display("[TB] FAIL stall_release_D2: got v=%0b c=%0h d=%0h expected v=1 c=12 d=%0h",
                            out_valid, out_ctrl, out_data, dval(12));
    end
    step();
    vecCount++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      missCount++; $display("[TB] FAIL stall_no_duplicate: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    vecCount++;
    if (stall_count !== 4'd3) begin missCount++; $display("[TB] FAIL stall_count_hold: got %0d expected 3", stall_count); end
  endtask

  task automatic test_flush();
    applyReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0020;
    in_data   = dval(20);
    step();
    in_ctrl = 16'h0021;
    in_data = dval(21);
    step();
    vecCount++;
    if (occupancy !== 2'd2) begin missCount++; $display("[TB] FAIL flush_prefill: got %0d expected 2", occupancy); end
    flush   = 1'b1;
    in_ctrl = 16'h0029;
    in_data = dval(9);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vecCount++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL flush_full: got v=%0b c=%0h occ=%0d rdy=%0b expected v=0 c=0 occ=0 rdy=1",
               out_valid, out_ctrl, occupancy, in_ready);
    end
    vecCount++;
    if (stall_count !== 4'd2) begin missCount++; $display("[TB] FAIL flush_stall_count: got %0d expected 2", stall_count); end
    in_valid  = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vecCount++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      missCount++; $display("[TB] FAIL flush_drops_input: got v=%0b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    step();
    vecCount++;
    if (out_valid !== 1'b0) begin missCount++; $display("[TB] FAIL flush_D9_absent: got %0b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    applyReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0030;
    in_data   = dval(30);
    step();
    in_ctrl = 16'h0031;
    in_data = dval(31);
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vecCount++;
    if (out_valid !== 1'b0 || out_ctrl !== 16'h0000) begin
      missCount++; $display("[TB] FAIL async_reset_out: got v=%0b c=%0h expected v=0 c=0", out_valid, out_ctrl);
    end
    vecCount++;
    if (occupancy !== 2'd0 || in_ready !== 1'b1 || stall_count !== 4'd0) begin
      missCount++; $display("[TB] FAIL async_reset_state: got occ=%0d rdy=%0b cnt=%0d expected occ=0 rdy=1 cnt=0",
                            occupancy, in_ready, stall_count);
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic test_saturate();
    int expCnt;
    applyReset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0040;
    in_data   = dval(40);
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      expCnt = (i > 15) ? 15 : i;
      vecCount++;
      if (stall_count !== 4'(expCnt)) begin
        missCount++; $display("[TB] FAIL saturate_cycle%0d: got %0d expected %0d", i, stall_count, expCnt);
      end
    end
    vecCount++;
    if (out_valid !== 1'b1 || out_data !== dval(40)) begin
      missCount++; $display("[TB] FAIL saturate_held_entry: got v=%0b d=%0h expected v=1 d=%0h", out_valid, out_data, dval(40));
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
